// File: rtl/abs_cmd_ctrl.sv
// abs_cmd_ctrl: Debug Module abstract command sequencer.
// Validates a command written by the debugger, issues one access on the
// CSR/GPR port, tracks busy/cmderr for abstractcs and returns read data to data0.

`ifndef DM_REG_WIDTH
`define DM_REG_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CMD_REGNO_SIZE
`define CMD_REGNO_SIZE 16
`endif
`ifndef CMD_CMDTYPE_RANGE
`define CMD_CMDTYPE_RANGE 31:24
`endif
`ifndef CMD_AARSIZE_RANGE
`define CMD_AARSIZE_RANGE 22:20
`endif
`ifndef CMD_POSTEXEC_RANGE
`define CMD_POSTEXEC_RANGE 18
`endif
`ifndef CMD_TRANSFER_RANGE
`define CMD_TRANSFER_RANGE 17
`endif
`ifndef CMD_WRITE_RANGE
`define CMD_WRITE_RANGE 16
`endif
`ifndef CMD_REGNO_RANGE
`define CMD_REGNO_RANGE 15:0
`endif

module abs_cmd_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_rstn,
    input  logic [`DM_REG_WIDTH-1:0]   command,
    input  logic                       cmd_update,
    input  logic [`DM_REG_WIDTH-1:0]   data0,
    input  logic                       hart_halted,
    input  logic [2:0]                 cmderr_w1c,
    output logic                       busy,
    output logic [2:0]                 cmderr,
    output logic                       access_req,
    output logic                       wr1_rd0,
    output logic [`CMD_REGNO_SIZE-1:0] regno,
    output logic [`DATA_WIDTH-1:0]     write_data,
    input  logic                       access_ack,
    input  logic [`DATA_WIDTH-1:0]     read_data,
    output logic                       data0_wr_en,
    output logic [`DATA_WIDTH-1:0]     data0_wr_data
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);

    localparam logic [2:0] ERR_BUSY       = 3'd1;
    localparam logic [2:0] ERR_NOTSUP     = 3'd2;
    localparam logic [2:0] ERR_EXCEPTION  = 3'd3;
    localparam logic [2:0] ERR_HALTRESUME = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    // Access parameters captured at accept and held until the next accept.
    typedef struct packed {
        logic                       wr;
        logic [`CMD_REGNO_SIZE-1:0] regno;
        logic [`DATA_WIDTH-1:0]     data;
    } acc_req_t;

    state_e             state_q, state_d;
    acc_req_t           req_q, req_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic [2:0]         cmderr_q, cmderr_d;
    logic               d0_en_q, d0_en_d;
    logic [`DATA_WIDTH-1:0] d0_data_q, d0_data_d;

    logic               err_set;
    logic [2:0]         err_val;
    logic               rd_done;
    logic               cmd_notsup;
    logic               unused_cmd_bits;

    // Fields this sequencer does not act on (aarpostincrement, reserved).
    assign unused_cmd_bits = &{1'b0, command[23], command[19]};

    // Anything other than a 32-bit access-register command without postexec.
    assign cmd_notsup = (command[`CMD_CMDTYPE_RANGE] != '0) ||
                        (command[`CMD_AARSIZE_RANGE] != 3'd2) ||
                        command[`CMD_POSTEXEC_RANGE];

    // Next-state, error and data0-return logic.
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        timer_d   = timer_q;
        err_set   = 1'b0;
        err_val   = 3'd0;
        rd_done   = 1'b0;

        // A command written while one is running is dropped and flagged.
        if (state_q != S_IDLE && cmd_update && cmderr_q == 3'd0) begin
            err_set = 1'b1;
            err_val = ERR_BUSY;
        end

        case (state_q)
            S_IDLE: begin
                // A pending error blocks new commands until software clears it.
                if (cmd_update && cmderr_q == 3'd0) begin
                    if (cmd_notsup) begin
                        err_set = 1'b1;
                        err_val = ERR_NOTSUP;
                    end else if (!hart_halted) begin
                        err_set = 1'b1;
                        err_val = ERR_HALTRESUME;
                    end else if (command[`CMD_TRANSFER_RANGE]) begin
                        req_d.wr    = command[`CMD_WRITE_RANGE];
                        req_d.regno = command[`CMD_REGNO_RANGE];
                        req_d.data  = data0[`DATA_WIDTH-1:0];
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                if (access_ack) begin
                    state_d = S_IDLE;
                    rd_done = !req_q.wr;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (access_ack) begin
                    state_d = S_IDLE;
                    rd_done = !req_q.wr;
                end else if (timer_q == TMAX) begin
                    state_d = S_IDLE;
                    err_set = 1'b1;
                    err_val = ERR_EXCEPTION;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Setting an error takes precedence over a simultaneous clear.
        cmderr_d  = err_set ? err_val : (cmderr_q & ~cmderr_w1c);
        d0_en_d   = rd_done;
        d0_data_d = rd_done ? read_data : d0_data_q;
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q   <= S_IDLE;
            req_q     <= '0;
            timer_q   <= '0;
            cmderr_q  <= 3'd0;
            d0_en_q   <= 1'b0;
            d0_data_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            timer_q   <= timer_d;
            cmderr_q  <= cmderr_d;
            d0_en_q   <= d0_en_d;
            d0_data_q <= d0_data_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign access_req    = (state_q == S_ISSUE);
    assign cmderr        = cmderr_q;
    assign wr1_rd0       = req_q.wr;
    assign regno         = req_q.regno;
    assign write_data    = req_q.data;
    assign data0_wr_en   = d0_en_q;
    assign data0_wr_data = d0_data_q;

endmodule

// File: tb/tb_abs_cmd_ctrl.sv
// Directed bench for abs_cmd_ctrl: reads, writes, rejected commands,
// busy collisions, timeout and mid-command reset.
module tb_abs_cmd_ctrl;

    logic        sys_clk;
    logic        sys_rstn;
    logic [31:0] command;
    logic        cmd_update;
    logic [31:0] data0;
    logic        hart_halted;
    logic [2:0]  cmderr_w1c;
    logic        busy;
    logic [2:0]  cmderr;
    logic        access_req;
    logic        wr1_rd0;
    logic [15:0] regno;
    logic [31:0] write_data;
    logic        access_ack;
    logic [31:0] read_data;
    logic        data0_wr_en;
    logic [31:0] data0_wr_data;

    int checks = 0;
    int errors = 0;

    abs_cmd_ctrl #(.TIMEOUT(16)) dut (
        .sys_clk       (sys_clk),
        .sys_rstn      (sys_rstn),
        .command       (command),
        .cmd_update    (cmd_update),
        .data0         (data0),
        .hart_halted   (hart_halted),
        .cmderr_w1c    (cmderr_w1c),
        .busy          (busy),
        .cmderr        (cmderr),
        .access_req    (access_req),
        .wr1_rd0       (wr1_rd0),
        .regno         (regno),
        .write_data    (write_data),
        .access_ack    (access_ack),
        .read_data     (read_data),
        .data0_wr_en   (data0_wr_en),
        .data0_wr_data (data0_wr_data)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    function automatic logic [31:0] mk_cmd(input logic [7:0] ct, input logic [2:0] sz,
                                           input logic pe, input logic tr, input logic wr,
                                           input logic [15:0] rn);
        return {ct, 1'b0, sz, 1'b0, pe, tr, wr, rn};
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Read with ack three cycles after access_req; busy high four cycles.
    task automatic run_read(input logic [15:0] rn, input logic [31:0] rd, input string tag);
        command    = mk_cmd(8'd0, 3'd2, 1'b0, 1'b1, 1'b0, rn);
        cmd_update = 1'b1;
        tick();
        chk({tag, ".c0.busy"}, busy, 1);
        chk({tag, ".c0.req"}, access_req, 1);
        chk({tag, ".c0.wr1rd0"}, wr1_rd0, 0);
        chk({tag, ".c0.regno"}, regno, rn);
        cmd_update = 1'b0;
        tick();
        chk({tag, ".c1.req"}, access_req, 0);
        chk({tag, ".c1.busy"}, busy, 1);
        tick();
        chk({tag, ".c2.busy"}, busy, 1);
        tick();
        chk({tag, ".c3.busy"}, busy, 1);
        chk({tag, ".c3.d0en"}, data0_wr_en, 0);
        access_ack = 1'b1;
        read_data  = rd;
        tick();
        access_ack = 1'b0;
        read_data  = 32'h0;
        chk({tag, ".c4.busy"}, busy, 0);
        chk({tag, ".c4.d0en"}, data0_wr_en, 1);
        chk({tag, ".c4.d0data"}, data0_wr_data, rd);
        chk({tag, ".c4.cmderr"}, cmderr, 0);
        chk({tag, ".c4.req"}, access_req, 0);
        tick();
        chk({tag, ".c5.d0en"}, data0_wr_en, 0);
    endtask

    initial begin
        sys_rstn    = 1'b0;
        command     = 32'h0;
        cmd_update  = 1'b0;
        data0       = 32'h0;
        hart_halted = 1'b1;
        cmderr_w1c  = 3'd0;
        access_ack  = 1'b0;
        read_data   = 32'h0;
        tick();
        tick();

        // Reset state
        chk("rst.busy", busy, 0);
        chk("rst.cmderr", cmderr, 0);
        chk("rst.req", access_req, 0);
        chk("rst.wr1rd0", wr1_rd0, 0);
        chk("rst.regno", regno, 0);
        chk("rst.wdata", write_data, 0);
        chk("rst.d0en", data0_wr_en, 0);
        chk("rst.d0data", data0_wr_data, 0);
        sys_rstn = 1'b1;
        tick();

        // Read 0x1001
        data0 = 32'h0BAD_F00D;
        run_read(16'h1001, 32'hDEADBEEF, "rd1");

        // Write 0x0300 with ack in the ISSUE cycle
        command    = mk_cmd(8'd0, 3'd2, 1'b0, 1'b1, 1'b1, 16'h0300);
        data0      = 32'h12345678;
        cmd_update = 1'b1;
        tick();
        chk("wr.req", access_req, 1);
        chk("wr.busy", busy, 1);
        chk("wr.wr1rd0", wr1_rd0, 1);
        chk("wr.regno", regno, 16'h0300);
        chk("wr.wdata", write_data, 32'h12345678);
        cmd_update = 1'b0;
        data0      = 32'h0;
        access_ack = 1'b1;
        tick();
        access_ack = 1'b0;
        chk("wr.done.busy", busy, 0);
        chk("wr.done.d0en", data0_wr_en, 0);
        chk("wr.done.req", access_req, 0);
        chk("wr.hold.wdata", write_data, 32'h12345678);
        chk("wr.hold.wr1rd0", wr1_rd0, 1);
        chk("wr.cmderr", cmderr, 0);
        tick();
        chk("wr.after.d0en", data0_wr_en, 0);

        // cmdtype=1 -> NOTSUP
        command    = mk_cmd(8'd1, 3'd2, 1'b0, 1'b1, 1'b0, 16'h1001);
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        chk("ct.cmderr", cmderr, 2);
        chk("ct.busy", busy, 0);
        chk("ct.req", access_req, 0);
        // partial clear of a bit that is not set keeps the error
        cmderr_w1c = 3'b001;
        tick();
        chk("ct.partclr", cmderr, 2);
        cmderr_w1c = 3'b111;
        tick();
        cmderr_w1c = 3'b000;
        chk("ct.clr", cmderr, 0);

        // aarsize=3 -> NOTSUP
        command    = mk_cmd(8'd0, 3'd3, 1'b0, 1'b1, 1'b0, 16'h1001);
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        chk("sz.cmderr", cmderr, 2);
        chk("sz.req", access_req, 0);
        cmderr_w1c = 3'b111;
        tick();
        cmderr_w1c = 3'b000;
        chk("sz.clr", cmderr, 0);

        // postexec=1 -> NOTSUP
        command    = mk_cmd(8'd0, 3'd2, 1'b1, 1'b1, 1'b0, 16'h1001);
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        chk("pe.cmderr", cmderr, 2);
        cmderr_w1c = 3'b111;
        tick();
        cmderr_w1c = 3'b000;

        // NOTSUP takes priority over HALTRESUME
        hart_halted = 1'b0;
        command     = mk_cmd(8'd1, 3'd2, 1'b0, 1'b1, 1'b0, 16'h1001);
        cmd_update  = 1'b1;
        tick();
        cmd_update  = 1'b0;
        chk("prio.cmderr", cmderr, 2);
        cmderr_w1c = 3'b111;
        tick();
        cmderr_w1c = 3'b000;

        // Hart running -> HALTRESUME
        command    = mk_cmd(8'd0, 3'd2, 1'b0, 1'b1, 1'b0, 16'h1001);
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        chk("hr.cmderr", cmderr, 4);
        chk("hr.busy", busy, 0);
        chk("hr.req", access_req, 0);
        cmderr_w1c = 3'b111;
        tick();
        cmderr_w1c  = 3'b000;
        hart_halted = 1'b1;
        chk("hr.clr", cmderr, 0);

        // transfer=0 -> success without access
        command    = mk_cmd(8'd0, 3'd2, 1'b0, 1'b0, 1'b1, 16'h0555);
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        chk("nt.cmderr", cmderr, 0);
        chk("nt.busy", busy, 0);
        chk("nt.req", access_req, 0);
        chk("nt.regno", regno, 16'h0300);

        // Busy collision: second command during WAIT
        command    = mk_cmd(8'd0, 3'd2, 1'b0, 1'b1, 1'b0, 16'h1001);
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        chk("bz.req", access_req, 1);
        tick();
        command    = mk_cmd(8'd0, 3'd2, 1'b0, 1'b1, 1'b1, 16'h0300);
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        chk("bz.cmderr", cmderr, 1);
        chk("bz.busy", busy, 1);
        chk("bz.regno", regno, 16'h1001);
        chk("bz.wr1rd0", wr1_rd0, 0);
        access_ack = 1'b1;
        read_data  = 32'hA5A5A5A5;
        tick();
        access_ack = 1'b0;
        read_data  = 32'h0;
        chk("bz.done.busy", busy, 0);
        chk("bz.done.d0en", data0_wr_en, 1);
        chk("bz.done.d0data", data0_wr_data, 32'hA5A5A5A5);
        chk("bz.done.cmderr", cmderr, 1);
        // third command ignored while cmderr=1
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        chk("bz.ign.busy", busy, 0);
        chk("bz.ign.req", access_req, 0);
        chk("bz.ign.cmderr", cmderr, 1);
        chk("bz.ign.regno", regno, 16'h1001);
        cmderr_w1c = 3'b001;
        tick();
        cmderr_w1c = 3'b000;
        chk("bz.clr", cmderr, 0);
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        chk("bz.acc.req", access_req, 1);
        chk("bz.acc.wr1rd0", wr1_rd0, 1);
        access_ack = 1'b1;
        tick();
        access_ack = 1'b0;
        chk("bz.acc.done", busy, 0);

        // Timeout: busy falls 17 cycles after access_req
        command    = mk_cmd(8'd0, 3'd2, 1'b0, 1'b1, 1'b0, 16'h2002);
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        chk("to.req", access_req, 1);
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk($sformatf("to.busy%0d", i), busy, 1);
        end
        chk("to.pre.cmderr", cmderr, 0);
        tick();
        chk("to.busy17", busy, 0);
        chk("to.cmderr", cmderr, 3);
        access_ack = 1'b1;
        read_data  = 32'h77777777;
        tick();
        access_ack = 1'b0;
        chk("to.late.d0en", data0_wr_en, 0);
        chk("to.late.busy", busy, 0);
        chk("to.late.cmderr", cmderr, 3);
        chk("to.late.d0data", data0_wr_data, 32'hA5A5A5A5);
        cmderr_w1c = 3'b111;
        tick();
        cmderr_w1c = 3'b000;
        chk("to.clr", cmderr, 0);

        // Reset during WAIT with a busy error pending
        command    = mk_cmd(8'd0, 3'd2, 1'b0, 1'b1, 1'b0, 16'h1001);
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        tick();
        cmd_update = 1'b1;
        tick();
        cmd_update = 1'b0;
        chk("rs.pre.cmderr", cmderr, 1);
        access_ack = 1'b1;
        read_data  = 32'h55555555;
        sys_rstn   = 1'b0;
        #1;
        chk("rs.busy", busy, 0);
        chk("rs.cmderr", cmderr, 0);
        chk("rs.req", access_req, 0);
        chk("rs.regno", regno, 0);
        chk("rs.d0data", data0_wr_data, 0);
        tick();
        sys_rstn = 1'b1;
        tick();
        access_ack = 1'b0;
        read_data  = 32'h0;
        chk("rs.ack.d0en", data0_wr_en, 0);
        chk("rs.ack.busy", busy, 0);
        run_read(16'h1001, 32'hDEADBEEF, "rd2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
